// File: rtl/moore_fsm_sequencer_pkg.sv
// Shared definitions for the Moore-detector sequencer: state encoding and default sizes.
package moore_fsm_sequencer_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_CNT_W = 4;
  localparam int unsigned STATE_W   = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_SHIFT = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/moore_fsm_sequencer_sat_counter.sv
// Up-counter with synchronous clear and enable; optionally holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W   = 4,
  parameter bit          SAT = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] MAX = '1;

  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      o_cnt <= '0;
    end else if (i_en && !(SAT && (o_cnt == MAX))) begin
      o_cnt <= o_cnt + W'(1);
    end
  end

endmodule

// File: rtl/moore_fsm_sequencer.sv
// Sequences a serial Moore detector: clears it, shifts a word into W bit by bit,
// and counts Zout hits with a one-cycle lag so each shifted bit is sampled once.
module moore_fsm_sequencer
  import moore_fsm_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_count,
  output logic             w_out,
  input  logic             z_in,
  output logic             det_reset_n
);

  localparam int unsigned BIT_W = $clog2(WIDTH);

  state_t             r_state;
  logic [WIDTH-1:0]   r_shreg;
  logic               r_busy;
  logic               r_done;
  logic               r_w_out;
  logic               r_det_reset_n;
  logic               r_z_valid;

  logic               w_accept;
  logic               w_in_clear;
  logic               w_in_shift;
  logic               w_last_bit;
  logic               w_cur_bit;
  logic [WIDTH-1:0]   w_shreg_next;
  logic [BIT_W-1:0]   w_bit_cnt;

  always_comb begin
    w_accept     = (r_state == S_IDLE) && start;
    w_in_clear   = (r_state == S_CLEAR);
    w_in_shift   = (r_state == S_SHIFT);
    w_last_bit   = (w_bit_cnt == BIT_W'(WIDTH - 1));
    w_cur_bit    = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    w_shreg_next = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
  end

  // Outputs are loaded on the transition into a state so they are valid for that whole state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_shreg       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_w_out       <= 1'b0;
      r_det_reset_n <= 1'b0;
      r_z_valid     <= 1'b0;
    end else begin
      r_done        <= 1'b0;
      r_w_out       <= 1'b0;
      r_det_reset_n <= 1'b1;
      r_z_valid     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_CLEAR;
            r_shreg       <= data_in;
            r_busy        <= 1'b1;
            r_det_reset_n <= 1'b0;
          end
        end
        S_CLEAR: begin
          r_state <= S_SHIFT;
          r_w_out <= w_cur_bit;
          r_shreg <= w_shreg_next;
        end
        S_SHIFT: begin
          // Zout for this bit shows up next cycle, so mark that cycle as a sample.
          r_z_valid <= 1'b1;
          if (w_last_bit) begin
            r_state <= S_DRAIN;
          end else begin
            r_w_out <= w_cur_bit;
            r_shreg <= w_shreg_next;
          end
        end
        S_DRAIN: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .W   (BIT_W),
    .SAT (1'b0)
  ) u_bit_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_in_clear),
    .i_en  (w_in_shift),
    .o_cnt (w_bit_cnt)
  );

  sat_counter #(
    .W   (CNT_W),
    .SAT (1'b1)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_accept),
    .i_en  (r_z_valid && z_in),
    .o_cnt (match_count)
  );

  assign busy        = r_busy;
  assign done        = r_done;
  assign w_out       = r_w_out;
  assign det_reset_n = r_det_reset_n;

endmodule
